flash_preset_sched: RTL and testbench

//  Sole master of the spi_flash port. Sequences preset persistence: after reset,

---
 rtl/midi_pkg.sv | 33 +++
 rtl/flash_backoff_cnt.sv | 50 +++++
 rtl/flash_preset_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_flash_preset_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : midi_pkg                                                         |
// | Shared types and constants for the preset persistence scheduler.          |
// |   sched_state_t : scheduler FSM state encoding                             |
// |   sched_phase_t : which kind of flash transaction is in flight             |
// |   PRESET_BASE_ADDR / PRESET_WORDS : default preset area layout             |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package midi_pkg;

  typedef enum logic [2:0] {
    ST_RST_PULSE = 3'd0,
    ST_LOAD_REQ  = 3'd1,
    ST_ERASE_REQ = 3'd2,
    ST_WRITE_REQ = 3'd3,
    ST_ACK_DROP  = 3'd4,
    ST_BACKOFF   = 3'd5,
    ST_IDLE      = 3'd6,
    ST_FAIL      = 3'd7
  } sched_state_t;

  typedef enum logic [1:0] {
    PH_LOAD  = 2'd0,
    PH_ERASE = 2'd1,
    PH_WRITE = 2'd2
  } sched_phase_t;

  localparam logic [23:0] PRESET_BASE_ADDR = 24'h1ffd80;
  localparam int          PRESET_WORDS     = 4;

endpackage
`default_nettype wire

// File: rtl/flash_backoff_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : flash_backoff_cnt                                                |
// | Retry back-off timer. A load arms it; while enabled it counts down and     |
// | asserts done in the last of GAP enabled cycles.                            |
// |   clk  in  1  system clock                                                 |
// |   rst  in  1  asynchronous, active-low reset                               |
// |   load in  1  arm the timer (takes priority over counting)                 |
// |   en   in  1  count enable (back-off window active)                        |
// |   done out 1  back-off window ends this cycle                              |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module flash_backoff_cnt #(
  parameter int GAP = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Loaded with GAP-1 so that the enabled window spans exactly GAP cycles,
  // the last of which (count 0) is the done cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(GAP - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign done = en && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/flash_preset_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : flash_preset_sched                                               |
// | Sole master of the spi_flash port. After reset pulses the flash reset and  |
// | loads WORDS preset words into the preset RAM; on save_req erases the       |
// | preset area and writes every word back. Retries are bounded.               |
// |   clk, rst (async active-low)                                              |
// |   save_req            : persist request pulse                              |
// |   f_rst_o/f_adr_o/f_dat_o/f_we_o/f_tga_o/f_stb_o : flash request side      |
// |   f_dat_i/f_ack_i/f_rty_i                         : flash response side    |
// |   mem_idx/mem_we/mem_wdata/mem_rdata              : preset RAM port        |
// |   word_valid, busy, fail                          : status                 |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module flash_preset_sched
  import midi_pkg::*;
#(
  parameter int          WORDS     = PRESET_WORDS,
  parameter logic [23:0] BASE_ADDR = PRESET_BASE_ADDR,
  parameter int          MAX_RETRY = 3,
  parameter int          RETRY_GAP = 1024,
  localparam int         IW        = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             save_req,
  output logic             f_rst_o,
  output logic [23:0]      f_adr_o,
  output logic [31:0]      f_dat_o,
  output logic             f_we_o,
  output logic             f_tga_o,
  output logic             f_stb_o,
  input  logic [31:0]      f_dat_i,
  input  logic             f_ack_i,
  input  logic             f_rty_i,
  output logic [IW-1:0]    mem_idx,
  output logic             mem_we,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [WORDS-1:0] word_valid,
  output logic             busy,
  output logic             fail
);

  localparam int          RW       = $clog2(MAX_RETRY + 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  sched_state_t     state_q, state_d;
  sched_phase_t     phase_q, phase_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             pend_q, pend_d;
  logic [WORDS-1:0] word_valid_q, word_valid_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;

  logic             bo_load;
  logic             bo_en;
  logic             bo_done;
  logic             start_save;
  logic [23:0]      word_adr;

  flash_backoff_cnt #(
    .GAP (RETRY_GAP)
  ) u_backoff (
    .clk  (clk),
    .rst  (rst),
    .load (bo_load),
    .en   (bo_en),
    .done (bo_done)
  );

  assign bo_en    = (state_q == ST_BACKOFF);
  assign word_adr = BASE_ADDR + {{(22 - IW){1'b0}}, idx_q, 2'b00};

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    idx_d        = idx_q;
    retry_d      = retry_q;
    pend_d       = pend_q;
    word_valid_d = word_valid_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    bo_load      = 1'b0;

    case (state_q)
      ST_RST_PULSE: begin
        state_d = ST_LOAD_REQ;
        phase_d = PH_LOAD;
        idx_d   = '0;
      end

      ST_LOAD_REQ, ST_ERASE_REQ, ST_WRITE_REQ: begin
        // A retry request outranks an acknowledge seen in the same cycle.
        if (f_rty_i) begin
          retry_d = retry_q + 1'b1;
          if (retry_q >= RW'(MAX_RETRY)) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_BACKOFF;
            bo_load = 1'b1;
          end
        end else if (f_ack_i) begin
          retry_d = '0;
          state_d = ST_ACK_DROP;
          if (state_q == ST_LOAD_REQ) begin
            mem_we_d            = 1'b1;
            mem_wdata_d         = f_dat_i;
            word_valid_d[idx_q] = 1'b1;
          end
        end
      end

      // Ack may be held for several cycles; advance only once it is gone so
      // a single ack never completes two transactions.
      ST_ACK_DROP: begin
        if (!f_ack_i) begin
          if (phase_q == PH_ERASE) begin
            state_d = ST_WRITE_REQ;
            phase_d = PH_WRITE;
            idx_d   = '0;
          end else if (idx_q == LAST_IDX) begin
            if (pend_q) begin
              state_d = ST_ERASE_REQ;
              phase_d = PH_ERASE;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = (phase_q == PH_LOAD) ? ST_LOAD_REQ : ST_WRITE_REQ;
          end
        end
      end

      ST_BACKOFF: begin
        if (bo_done) begin
          case (phase_q)
            PH_ERASE: state_d = ST_ERASE_REQ;
            PH_WRITE: state_d = ST_WRITE_REQ;
            default:  state_d = ST_LOAD_REQ;
          endcase
        end
      end

      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_ERASE_REQ;
          phase_d = PH_ERASE;
        end
      end

      ST_FAIL: begin
        state_d = ST_FAIL;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Only a fresh save start consumes the pending request; re-entering the
    // erase after a back-off must not swallow a request made meanwhile.
    if (start_save) begin
      pend_d = 1'b0;
    end
    if (save_req && (state_q != ST_FAIL)) begin
      pend_d = 1'b1;
    end
  end

  assign start_save = (state_d == ST_ERASE_REQ) &&
                      ((state_q == ST_IDLE) || (state_q == ST_ACK_DROP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RST_PULSE;
      phase_q      <= PH_LOAD;
      idx_q        <= '0;
      retry_q      <= '0;
      pend_q       <= 1'b0;
      word_valid_q <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      retry_q      <= retry_d;
      pend_q       <= pend_d;
      word_valid_q <= word_valid_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Flash request outputs decode straight from the state so that an
  // asynchronous reset removes the strobe without waiting for a clock.
  assign f_rst_o = (state_q == ST_RST_PULSE);
  assign f_stb_o = (state_q == ST_LOAD_REQ) || (state_q == ST_ERASE_REQ) ||
                   (state_q == ST_WRITE_REQ);
  assign f_we_o  = (state_q == ST_ERASE_REQ) || (state_q == ST_WRITE_REQ);
  assign f_tga_o = (state_q == ST_ERASE_REQ);
  assign f_adr_o = (state_q == ST_ERASE_REQ) ? BASE_ADDR :
                   ((state_q == ST_LOAD_REQ) || (state_q == ST_WRITE_REQ)) ? word_adr :
                   24'd0;
  assign f_dat_o = (state_q == ST_WRITE_REQ) ? mem_rdata : 32'd0;

  assign mem_idx    = idx_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_valid = word_valid_q;

  // The reset-pulse cycle reads as not busy so every output but f_rst_o is
  // low while reset is held.
  assign busy = (state_q != ST_IDLE) && (state_q != ST_FAIL) &&
                (state_q != ST_RST_PULSE);
  assign fail = (state_q == ST_FAIL);

endmodule
`default_nettype wire

// File: tb/tb_flash_preset_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_flash_preset_sched                                            |
// | Self-checking bench: plays the flash device and the preset RAM, and checks |
// | every flash transaction against the sequence implied by boot/save rules.   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_flash_preset_sched;

  localparam int          WORDS = 4;
  localparam logic [23:0] BASE  = 24'h1ffd80;
  localparam int          GAP   = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        save_req = 1'b0;
  logic [31:0] f_dat_i = 32'd0;
  logic        f_ack_i = 1'b0;
  logic        f_rty_i = 1'b0;

  wire         f_rst_o;
  wire [23:0]  f_adr_o;
  wire [31:0]  f_dat_o;
  wire         f_we_o;
  wire         f_tga_o;
  wire         f_stb_o;
  wire [1:0]   mem_idx;
  wire         mem_we;
  wire [31:0]  mem_wdata;
  wire [31:0]  mem_rdata;
  wire [3:0]   word_valid;
  wire         busy;
  wire         fail;

  flash_preset_sched dut (
    .clk        (clk),
    .rst        (rst),
    .save_req   (save_req),
    .f_rst_o    (f_rst_o),
    .f_adr_o    (f_adr_o),
    .f_dat_o    (f_dat_o),
    .f_we_o     (f_we_o),
    .f_tga_o    (f_tga_o),
    .f_stb_o    (f_stb_o),
    .f_dat_i    (f_dat_i),
    .f_ack_i    (f_ack_i),
    .f_rty_i    (f_rty_i),
    .mem_idx    (mem_idx),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .word_valid (word_valid),
    .busy       (busy),
    .fail       (fail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt   = 0;
  int rst_hi   = 0;

  // Words the bench hands out on loads; saves must write these back.
  logic [31:0] exp_w [WORDS];
  // Preset RAM seen by the DUT.
  logic [31:0] ram [WORDS];

  assign mem_rdata = ram[mem_idx];

  always @(posedge clk) begin
    if (mem_we) ram[mem_idx] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_we) we_cnt <= we_cnt + 1;
    if (rst && f_rst_o) rst_hi <= rst_hi + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_stb(input string tag);
    int n;
    n = 0;
    while (f_stb_o !== 1'b1 && n < 3 * GAP) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " stb rise"}, 64'(f_stb_o), 64'd1);
  endtask

  // One flash transaction: expected kind is given as we/tga and word index k.
  task automatic serve(input string tag, input logic we, input logic tga, input int k,
                       input logic [31:0] rdat, input int hold, input bit pulse_save);
    int          c0;
    logic [23:0] adr;
    adr = tga ? BASE : 24'(BASE + 24'(4 * k));
    wait_stb(tag);
    chk({tag, " req"}, 64'({f_we_o, f_tga_o, f_adr_o}), 64'({we, tga, adr}));
    chk({tag, " busy"}, 64'(busy), 64'd1);
    if (we && !tga) chk({tag, " wdata"}, 64'(f_dat_o), 64'(exp_w[k]));
    if (pulse_save) begin
      save_req = 1'b1;
      @(negedge clk);
      save_req = 1'b0;
      chk({tag, " hold"}, 64'({f_stb_o, f_we_o, f_tga_o, f_adr_o}), 64'({1'b1, we, tga, adr}));
    end
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk({tag, " hold"}, 64'({f_stb_o, f_we_o, f_tga_o, f_adr_o}), 64'({1'b1, we, tga, adr}));
    end
    c0 = we_cnt;
    f_ack_i = 1'b1;
    f_dat_i = rdat;
    @(negedge clk);
    chk({tag, " stb drop"}, 64'(f_stb_o), 64'd0);
    if (!we) begin
      chk({tag, " mem_we"}, 64'(mem_we), 64'd1);
      chk({tag, " mem_idx"}, 64'(mem_idx), 64'(k));
      chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'(rdat));
    end
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " stb during held ack"}, 64'(f_stb_o), 64'd0);
    end
    f_ack_i = 1'b0;
    f_dat_i = $urandom;
    #1;
    chk({tag, " mem_we count"}, 64'(we_cnt - c0), 64'(we ? 0 : 1));
  endtask

  task automatic boot(input int hold0, input int hold_rest, input bit save_on1);
    for (int k = 0; k < WORDS; k++) begin
      serve("load", 1'b0, 1'b0, k, exp_w[k], (k == 0) ? hold0 : hold_rest, save_on1 && (k == 1));
      chk("word_valid progress", 64'(word_valid), 64'((1 << (k + 1)) - 1));
    end
  endtask

  task automatic save_all(input bit pulse_erase, input bit pulse_w2);
    serve("erase", 1'b1, 1'b1, 0, $urandom, $urandom_range(1, 3), pulse_erase);
    for (int k = 0; k < WORDS; k++)
      serve("write", 1'b1, 1'b0, k, $urandom, $urandom_range(1, 3), pulse_w2 && (k == 2));
  endtask

  task automatic quiet(input string tag, input int cycles);
    int hi;
    hi = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (f_stb_o !== 1'b0) hi++;
    end
    chk({tag, " no strobe"}, 64'(hi), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
  endtask

  task automatic pulse_save;
    @(negedge clk);
    save_req = 1'b1;
    @(negedge clk);
    save_req = 1'b0;
  endtask

  initial begin
    int r0;
    int gap;

    for (int k = 0; k < WORDS; k++) exp_w[k] = 32'hB02E7F1E + 32'(k);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset f_rst_o", 64'(f_rst_o), 64'd1);
    chk("reset ctl", 64'({f_stb_o, f_we_o, f_tga_o, mem_we, busy, fail, word_valid}), 64'd0);
    chk("reset adr/dat", 64'({f_adr_o, f_dat_o}), 64'd0);
    r0 = rst_hi;
    @(posedge clk);
    #1 rst = 1'b1;

    // Boot load
    boot(2, 2, 1'b0);
    repeat (2) @(negedge clk);
    chk("boot f_rst_o cycles", 64'(rst_hi - r0), 64'd1);
    chk("boot busy", 64'(busy), 64'd0);
    chk("boot word_valid", 64'(word_valid), 64'hF);
    for (int k = 0; k < WORDS; k++) chk("boot ram", 64'(ram[k]), 64'(exp_w[k]));

    // Save from IDLE with latency check
    @(negedge clk);
    save_req = 1'b1;
    @(negedge clk);
    save_req = 1'b0;
    chk("save latency +1", 64'(f_stb_o), 64'd0);
    @(negedge clk);
    chk("save latency +2", 64'(f_stb_o), 64'd1);
    save_all(1'b0, 1'b0);
    quiet("after save", 20);

    // Reset in the middle of a write
    pulse_save();
    serve("erase", 1'b1, 1'b1, 0, $urandom, 1, 1'b0);
    serve("write", 1'b1, 1'b0, 0, $urandom, 2, 1'b0);
    wait_stb("write1 before rst");
    rst = 1'b0;
    #1;
    chk("async stb drop", 64'(f_stb_o), 64'd0);
    chk("rst word_valid", 64'(word_valid), 64'd0);
    chk("rst f_rst_o", 64'(f_rst_o), 64'd1);
    repeat (2) @(negedge clk);
    r0 = rst_hi;
    @(posedge clk);
    #1 rst = 1'b1;

    // Reload with held first ack, save requested mid-load and twice mid-save
    for (int k = 0; k < WORDS; k++) exp_w[k] = $urandom;
    boot(5, 1, 1'b1);
    chk("reload f_rst_o cycles", 64'(rst_hi - r0), 64'd1);
    chk("reload word_valid", 64'(word_valid), 64'hF);
    save_all(1'b1, 1'b1);
    save_all(1'b0, 1'b0);
    quiet("after coalesced saves", 30);

    // Retries exhausted on write 2
    pulse_save();
    serve("erase", 1'b1, 1'b1, 0, $urandom, 1, 1'b0);
    serve("write", 1'b1, 1'b0, 0, $urandom, 1, 1'b0);
    serve("write", 1'b1, 1'b0, 1, $urandom, 2, 1'b0);
    for (int r = 0; r < 4; r++) begin
      wait_stb("retry write2");
      chk("retry req", 64'({f_we_o, f_tga_o, f_adr_o}), 64'({1'b1, 1'b0, 24'(BASE + 24'd8)}));
      chk("retry wdata", 64'(f_dat_o), 64'(exp_w[2]));
      f_rty_i = 1'b1;
      f_ack_i = (r == 0);
      @(negedge clk);
      f_rty_i = 1'b0;
      f_ack_i = 1'b0;
      chk("retry stb drop", 64'(f_stb_o), 64'd0);
      if (r < 3) begin
        gap = 1;
        while (f_stb_o !== 1'b1 && gap < 2 * GAP) begin
          @(negedge clk);
          if (f_stb_o !== 1'b1) gap++;
        end
        chk("retry gap", 64'(gap), 64'(GAP));
      end
    end
    chk("fail flag", 64'(fail), 64'd1);
    chk("fail busy", 64'(busy), 64'd0);
    pulse_save();
    quiet("in FAIL", 30);
    chk("fail sticky", 64'(fail), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
